nes_rom_loader: RTL and testbench
=================================

Name: nes_rom_loader

Overview:
- Sits directly downstream of the SPI file-download stage.
- Consumes its byte stream (write strobe plus data, clk domain) while downloading is high, and parses the 16-byte iNES header.
- Strips the header and any trainer, then re-addresses PRG and CHR bytes into separate regions of cartridge memory through a req/ack write port.
- Publishes the decoded cartridge description (mapper, mirroring, sizes) to the NES core.

Parameters:
- MEM_AW, 22, width of memory byte address.
- CHR_BASE, 22'h200000, memory byte address of CHR region start; PRG region starts at 0.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  reset, asynchronous, active-high.
- downloading  in  1  high for the duration of a file transfer (from download stage).
- ioctl_wr  in  1  one-cycle strobe: ioctl_data valid.
- ioctl_data  in  8  downloaded byte.
- mem_req  out  1  write request, held until acknowledged.
- mem_addr  out  MEM_AW  write byte address.
- mem_data  out  8  write data.
- mem_ack  in  1  memory accepted the write this cycle.
- mapper  out  8  {byte7[7:4], byte6[7:4]}.
- mirroring  out  1  byte6[0] (1 = vertical).
- four_screen  out  1  byte6[3].
- prg_banks  out  8  header byte4 (16 KiB units).
- chr_banks  out  8  header byte5 (8 KiB units); 0 means CHR RAM.
- busy  out  1  high in HEADER/TRAINER/PRG/CHR.
- done  out  1  sticky: complete image loaded.
- error  out  2  sticky: 0 none, 1 bad magic/zero PRG, 2 truncated, 3 overflow.

Behaviour:
- Reset values:
  - state IDLE; mem_req=0, mem_addr=0, mem_data=0.
  - All header outputs 0; busy=0, done=0, error=0; byte counter 0.
- States: IDLE, HEADER, TRAINER, PRG, CHR, DONE, ERROR.
- Rising edge of downloading (registered compare) in any state:
  - go to HEADER.
  - Clear done, error, counter and all header outputs.
  - Drop any pending mem_req.
- HEADER, 16 bytes, counter 0..15, no memory writes:
  - Bytes 0..3 must equal 4E 45 53 1A. A mismatch goes to ERROR, error=1, at that byte.
  - Bytes 4..7 latch prg_banks, chr_banks, flags6, flags7. Outputs update on the byte's strobe +1 cycle.
  - Bytes 8..15 are ignored.
  - After byte 15:
    - prg_banks==0 goes to ERROR, error=1.
    - Otherwise flags6[2] set goes to TRAINER.
    - Otherwise go to PRG.
  - Counter resets to 0 on every state change.
- TRAINER: consume 512 bytes, no writes, then go to PRG.
- PRG:
  - Each byte n is written to address n.
  - Length is prg_banks*16384, computed by shifting left 14, MEM_AW wide, no multiplier.
  - After the last byte: chr_banks==0 goes to DONE; otherwise go to CHR.
- CHR:
  - Each byte n is written to address CHR_BASE+n.
  - Length is chr_banks*8192.
  - After the last byte, go to DONE.
- DONE: done=1; further bytes are ignored (no writes, no error).
- ERROR: all further bytes are ignored until the next rising edge of downloading.
- Falling edge of downloading in HEADER/TRAINER/PRG/CHR:
  - go to ERROR, error=2 (truncated).
  - A pending write still completes.
- Write handshake:
  - A byte accepted on an ioctl_wr cycle drives mem_req=1 with mem_addr/mem_data on the next cycle (latency 1).
  - mem_req, mem_addr and mem_data stay stable until the cycle mem_ack=1; mem_req drops the following cycle unless a new byte was accepted in the ack cycle.
  - ioctl_wr with mem_ack=1 in the same cycle is legal. The new byte is loaded and mem_req stays high (back-to-back).
  - ioctl_wr while mem_req=1 and mem_ack=0: go to ERROR, error=3; the new byte is dropped; the pending write completes.
- Reset mid-operation returns all outputs to their reset values immediately. The memory side must tolerate mem_req deasserting without ack.
- Address arithmetic:
  - Offsets wrap modulo 2^MEM_AW.
  - Sizes exceeding the region are not checked. PRG max is 255*16 KiB, which fits 22 bits; CHR_BASE+offset may wrap, and this is accepted.
- busy = state in {HEADER, TRAINER, PRG, CHR}, registered.

Decomposition:
- Package nes_loader_pkg holds:
  - state enum.
  - error code constants ERR_NONE/ERR_HDR/ERR_TRUNC/ERR_OVF.
  - iNES magic constants.
  - header byte index constants.
  - PRG/CHR unit shift constants 14/13.
- One sub-module, loader_wr_buf: a single-entry holding register implementing the req/ack rules and raising the overflow indication.
- Header parsing and the FSM stay in the top module.

Test Plan:
- Valid image, magic OK, byte4=1, byte5=1, flags6=0x01, 24576 payload bytes, mem_ack on the cycle after each req:
  - prg writes to 0..0x3FFF, chr writes to 0x200000..0x201FFF.
  - mirroring=1, mapper=0, done=1, error=0.
- Trainer plus CHR RAM, flags6=0x04, byte5=0, 512+16384 payload bytes:
  - first write is address 0 with data equal to payload byte 512.
  - exactly 16384 writes, done=1 after the last.
- Bad magic, byte2=0x54:
  - error=1 on that byte, zero writes, and no further writes for the remaining stream.
  - A new rising edge of downloading with a valid image clears the error and loads normally.
- Truncation: downloading falls after 1000 PRG bytes with byte4=2 → error=2, done=0, exactly 1000 writes.
- Memory stall: hold mem_ack=0 for 20 cycles while a second ioctl_wr arrives → error=3; the first write is retained and completes on ack.
- Back-to-back ioctl_wr coincident with mem_ack → no overflow, mem_req stays high, consecutive addresses.
- Reset asserted mid-PRG → mem_req=0, busy=0 and all header outputs 0 within the same cycle.

Source files
------------

// File: rtl/nes_rom_loader_pkg.sv
// Shared types and constants for the iNES ROM loader: FSM states, error codes,
// header layout and bank-size shifts.
package nes_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_TRAINER,
        ST_PRG,
        ST_CHR,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_HDR   = 2'd1;
    localparam logic [1:0] ERR_TRUNC = 2'd2;
    localparam logic [1:0] ERR_OVF   = 2'd3;

    localparam logic [7:0] INES_MAGIC0 = 8'h4E;
    localparam logic [7:0] INES_MAGIC1 = 8'h45;
    localparam logic [7:0] INES_MAGIC2 = 8'h53;
    localparam logic [7:0] INES_MAGIC3 = 8'h1A;

    localparam int unsigned HDR_PRG    = 4;
    localparam int unsigned HDR_CHR    = 5;
    localparam int unsigned HDR_FLAGS6 = 6;
    localparam int unsigned HDR_FLAGS7 = 7;
    localparam int unsigned HDR_LAST   = 15;

    localparam int unsigned PRG_UNIT_SHIFT = 14;
    localparam int unsigned CHR_UNIT_SHIFT = 13;
    localparam int unsigned TRAINER_LEN    = 512;

    function automatic logic [7:0] ines_magic(input logic [1:0] idx);
        case (idx)
            2'd0:    return INES_MAGIC0;
            2'd1:    return INES_MAGIC1;
            2'd2:    return INES_MAGIC2;
            default: return INES_MAGIC3;
        endcase
    endfunction

    function automatic logic is_active(input state_t s);
        return (s == ST_HEADER) || (s == ST_TRAINER) || (s == ST_PRG) || (s == ST_CHR);
    endfunction

endpackage

// File: rtl/nes_rom_loader_if.sv
// Cartridge memory write port: req/ack handshake carrying one byte per transfer.
interface nes_rom_loader_if #(
    parameter int unsigned MEM_AW = 22
);
    logic              mem_req;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_ack;

    modport master (output mem_req, output mem_addr, output mem_data, input mem_ack);
    modport slave  (input mem_req, input mem_addr, input mem_data, output mem_ack);
endinterface

// File: rtl/nes_rom_loader_wr_buf.sv
// Single-entry write holding register: presents one byte on the memory port
// until acknowledged and flags a push that arrives while the entry is stalled.
module loader_wr_buf #(
    parameter int unsigned MEM_AW = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [MEM_AW-1:0] addr,
    input  logic [7:0]        data,
    output logic              ovf,
    nes_rom_loader_if.master  mem
);

    logic can_load;

    // The entry frees up in the ack cycle, so a coincident push is back-to-back.
    assign can_load = !mem.mem_req || mem.mem_ack;
    assign ovf      = push && !can_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_data <= '0;
        end else if (flush) begin
            mem.mem_req <= 1'b0;
        end else if (push && can_load) begin
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= addr;
            mem.mem_data <= data;
        end else if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
        end
    end

endmodule

// File: rtl/nes_rom_loader.sv
// iNES loader: parses the 16-byte header from the download stream, skips any
// trainer, and writes PRG/CHR payload into separate cartridge memory regions.
module nes_rom_loader
    import nes_loader_pkg::*;
#(
    parameter int unsigned       MEM_AW   = 22,
    parameter logic [MEM_AW-1:0] CHR_BASE = 22'h200000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             downloading,
    input  logic             ioctl_wr,
    input  logic [7:0]       ioctl_data,
    nes_rom_loader_if.master mem,
    output logic [7:0]       mapper,
    output logic             mirroring,
    output logic             four_screen,
    output logic [7:0]       prg_banks,
    output logic [7:0]       chr_banks,
    output logic             busy,
    output logic             done,
    output logic [1:0]       error
);

    state_t            state, state_n;
    logic [MEM_AW-1:0] cnt, cnt_n;
    logic              dl_q;
    logic [7:0]        prg_q, prg_n, chr_q, chr_n, mapper_q, mapper_n;
    logic              mirr_q, mirr_n, four_q, four_n, trainer_q, trainer_n;
    logic              done_q, done_n, busy_q, busy_n;
    logic [1:0]        err_q, err_n;

    logic              dl_rise, dl_fall;
    logic              wr_push, wr_ovf;
    logic [MEM_AW-1:0] wr_addr, prg_last, chr_last;

    assign dl_rise = downloading && !dl_q;
    assign dl_fall = !downloading && dl_q;

    assign prg_last = (MEM_AW'(prg_q) << PRG_UNIT_SHIFT) - MEM_AW'(1);
    assign chr_last = (MEM_AW'(chr_q) << CHR_UNIT_SHIFT) - MEM_AW'(1);

    assign wr_push = ioctl_wr && !dl_rise && !dl_fall && (state == ST_PRG || state == ST_CHR);
    assign wr_addr = (state == ST_CHR) ? CHR_BASE + cnt : cnt;

    loader_wr_buf #(.MEM_AW(MEM_AW)) u_wr_buf (
        .clk   (clk),
        .reset (reset),
        .flush (dl_rise),
        .push  (wr_push),
        .addr  (wr_addr),
        .data  (ioctl_data),
        .ovf   (wr_ovf),
        .mem   (mem)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dl_q      <= 1'b0;
            prg_q     <= '0;
            chr_q     <= '0;
            mapper_q  <= '0;
            mirr_q    <= 1'b0;
            four_q    <= 1'b0;
            trainer_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= ERR_NONE;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dl_q      <= downloading;
            prg_q     <= prg_n;
            chr_q     <= chr_n;
            mapper_q  <= mapper_n;
            mirr_q    <= mirr_n;
            four_q    <= four_n;
            trainer_q <= trainer_n;
            done_q    <= done_n;
            busy_q    <= busy_n;
            err_q     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        prg_n     = prg_q;
        chr_n     = chr_q;
        mapper_n  = mapper_q;
        mirr_n    = mirr_q;
        four_n    = four_q;
        trainer_n = trainer_q;
        done_n    = done_q;
        err_n     = err_q;

        if (dl_rise) begin
            state_n   = ST_HEADER;
            cnt_n     = '0;
            prg_n     = '0;
            chr_n     = '0;
            mapper_n  = '0;
            mirr_n    = 1'b0;
            four_n    = 1'b0;
            trainer_n = 1'b0;
            done_n    = 1'b0;
            err_n     = ERR_NONE;
        end else if (dl_fall && is_active(state)) begin
            state_n = ST_ERROR;
            cnt_n   = '0;
            err_n   = ERR_TRUNC;
        end else if (ioctl_wr) begin
            unique case (state)
                ST_HEADER: begin
                    cnt_n = cnt + MEM_AW'(1);
                    if (cnt < MEM_AW'(4) && ioctl_data != ines_magic(cnt[1:0])) begin
                        state_n = ST_ERROR;
                        cnt_n   = '0;
                        err_n   = ERR_HDR;
                    end else begin
                        case (cnt[3:0])
                            4'(HDR_PRG):    prg_n = ioctl_data;
                            4'(HDR_CHR):    chr_n = ioctl_data;
                            4'(HDR_FLAGS6): begin
                                mapper_n[3:0] = ioctl_data[7:4];
                                four_n        = ioctl_data[3];
                                trainer_n     = ioctl_data[2];
                                mirr_n        = ioctl_data[0];
                            end
                            4'(HDR_FLAGS7): mapper_n[7:4] = ioctl_data[7:4];
                            default: ;
                        endcase
                        if (cnt[3:0] == 4'(HDR_LAST)) begin
                            cnt_n = '0;
                            if (prg_q == '0) begin
                                state_n = ST_ERROR;
                                err_n   = ERR_HDR;
                            end else if (trainer_q) begin
                                state_n = ST_TRAINER;
                            end else begin
                                state_n = ST_PRG;
                            end
                        end
                    end
                end
                ST_TRAINER: begin
                    cnt_n = cnt + MEM_AW'(1);
                    if (cnt == MEM_AW'(TRAINER_LEN - 1)) begin
                        state_n = ST_PRG;
                        cnt_n   = '0;
                    end
                end
                ST_PRG, ST_CHR: begin
                    cnt_n = cnt + MEM_AW'(1);
                    if (wr_ovf) begin
                        state_n = ST_ERROR;
                        cnt_n   = '0;
                        err_n   = ERR_OVF;
                    end else if (state == ST_PRG && cnt == prg_last) begin
                        cnt_n = '0;
                        if (chr_q == '0) begin
                            state_n = ST_DONE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = ST_CHR;
                        end
                    end else if (state == ST_CHR && cnt == chr_last) begin
                        cnt_n   = '0;
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        busy_n = is_active(state_n);
    end

    assign mapper      = mapper_q;
    assign mirroring   = mirr_q;
    assign four_screen = four_q;
    assign prg_banks   = prg_q;
    assign chr_banks   = chr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = err_q;

endmodule

// File: tb/tb_nes_rom_loader.sv
// Scoreboard bench for nes_rom_loader: expected writes are queued as payload is
// driven and matched by the memory model as each write is acknowledged.
module tb_nes_rom_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       downloading;
    logic       ioctl_wr;
    logic [7:0] ioctl_data;
    logic [7:0] mapper, prg_banks, chr_banks;
    logic       mirroring, four_screen, busy, done;
    logic [1:0] error;

    nes_rom_loader_if #(.MEM_AW(22)) mem ();

    nes_rom_loader #(.MEM_AW(22), .CHR_BASE(22'h200000)) dut (
        .clk         (clk),
        .reset       (reset),
        .downloading (downloading),
        .ioctl_wr    (ioctl_wr),
        .ioctl_data  (ioctl_data),
        .mem         (mem),
        .mapper      (mapper),
        .mirroring   (mirroring),
        .four_screen (four_screen),
        .prg_banks   (prg_banks),
        .chr_banks   (chr_banks),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: acks ack_delay cycles after req is seen, unless stalled.
    logic [29:0] sb[$];
    logic        stall = 1'b0;
    int unsigned ack_delay = 0;
    int unsigned ack_wait = 0;
    int unsigned wr_count = 0;

    always @(negedge clk) begin
        logic [29:0] exp;
        if (reset || !mem.mem_req || stall) begin
            mem.mem_ack = 1'b0;
            ack_wait    = 0;
        end else if (ack_wait >= ack_delay) begin
            mem.mem_ack = 1'b1;
            ack_wait    = 0;
            wr_count++;
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("wr_addr", 32'(mem.mem_addr), 32'(exp[29:8]));
                check("wr_data", 32'(mem.mem_data), 32'(exp[7:0]));
            end
        end else begin
            mem.mem_ack = 1'b0;
            ack_wait++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int unsigned stride);
        ioctl_wr   = 1'b1;
        ioctl_data = b;
        @(negedge clk);
        if (stride > 1) begin
            ioctl_wr = 1'b0;
            repeat (stride - 1) @(negedge clk);
        end
    endtask

    task automatic send_header(input logic [7:0] prg, input logic [7:0] chr,
                               input logic [7:0] f6, input logic [7:0] f7,
                               input int unsigned stride);
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            case (i)
                0: b = 8'h4E;
                1: b = 8'h45;
                2: b = 8'h53;
                3: b = 8'h1A;
                4: b = prg;
                5: b = chr;
                6: b = f6;
                7: b = f7;
                default: b = 8'($urandom);
            endcase
            send_byte(b, stride);
            if (i == 4) check("hdr_prg_latch", 32'(prg_banks), 32'(prg));
        end
    endtask

    task automatic send_payload(input logic [21:0] base, input int unsigned n, input int unsigned stride);
        logic [7:0] b;
        for (int unsigned i = 0; i < n; i++) begin
            b = 8'($urandom);
            sb.push_back({base + 22'(i), b});
            send_byte(b, stride);
        end
    endtask

    task automatic start_download();
        ioctl_wr    = 1'b0;
        downloading = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_download();
        ioctl_wr    = 1'b0;
        downloading = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 500; i++) begin
            if (sb.size() == 0 && !mem.mem_req) break;
            @(negedge clk);
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned wr0;
        logic [7:0]  a_byte;

        reset       = 1'b1;
        downloading = 1'b0;
        ioctl_wr    = 1'b0;
        ioctl_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(mem.mem_req), 32'd0);
        check("rst_addr", 32'(mem.mem_addr), 32'd0);
        check("rst_data", 32'(mem.mem_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_mapper", 32'(mapper), 32'd0);
        check("rst_prg", 32'(prg_banks), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Valid image with PRG and CHR, ack one cycle after req
        ack_delay = 1;
        wr0 = wr_count;
        start_download();
        check("t1_busy", 32'(busy), 32'd1);
        send_header(8'd1, 8'd1, 8'h01, 8'h00, 2);
        send_payload(22'h000000, 16384, 2);
        send_payload(22'h200000, 8192, 2);
        ioctl_wr = 1'b0;
        drain("t1_drain");
        check("t1_wr_count", wr_count - wr0, 32'd24576);
        check("t1_done", 32'(done), 32'd1);
        check("t1_error", 32'(error), 32'd0);
        check("t1_mirroring", 32'(mirroring), 32'd1);
        check("t1_mapper", 32'(mapper), 32'd0);
        check("t1_four", 32'(four_screen), 32'd0);
        check("t1_chr", 32'(chr_banks), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        end_download();
        check("t1_done_after_fall", 32'(done), 32'd1);
        check("t1_err_after_fall", 32'(error), 32'd0);

        // Trainer, CHR RAM, back-to-back strobes coincident with ack
        ack_delay = 0;
        wr0 = wr_count;
        start_download();
        send_header(8'd1, 8'd0, 8'h04, 8'h00, 1);
        for (int i = 0; i < 512; i++) send_byte(8'($urandom), 1);
        send_payload(22'd0, 100, 1);
        check("b2b_req_high", 32'(mem.mem_req), 32'd1);
        check("b2b_no_ovf", 32'(error), 32'd0);
        send_payload(22'd100, 16283, 1);
        check("t2_done_early", 32'(done), 32'd0);
        send_payload(22'd16383, 1, 1);
        ioctl_wr = 1'b0;
        check("t2_done_last", 32'(done), 32'd1);
        drain("t2_drain");
        check("t2_wr_count", wr_count - wr0, 32'd16384);
        check("t2_error", 32'(error), 32'd0);
        end_download();

        // Bad magic, then a fresh download recovers
        wr0 = wr_count;
        start_download();
        send_byte(8'h4E, 1);
        send_byte(8'h45, 1);
        send_byte(8'h54, 1);
        check("t3_err_hdr", 32'(error), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 113; i++) send_byte(8'($urandom), 1);
        ioctl_wr = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_no_writes", wr_count - wr0, 32'd0);
        check("t3_err_sticky", 32'(error), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        end_download();
        start_download();
        check("t3_err_cleared", 32'(error), 32'd0);
        check("t3_busy_again", 32'(busy), 32'd1);
        send_header(8'd1, 8'd0, 8'h00, 8'h10, 1);
        send_payload(22'd0, 16384, 1);
        ioctl_wr = 1'b0;
        drain("t3_drain");
        check("t3_wr_count", wr_count - wr0, 32'd16384);
        check("t3_done_reload", 32'(done), 32'd1);
        check("t3_mapper", 32'(mapper), 32'h10);
        end_download();

        // Truncated download
        wr0 = wr_count;
        start_download();
        send_header(8'd2, 8'd0, 8'h00, 8'h00, 1);
        send_payload(22'd0, 1000, 1);
        ioctl_wr    = 1'b0;
        downloading = 1'b0;
        @(negedge clk);
        check("t4_err_trunc", 32'(error), 32'd2);
        check("t4_done", 32'(done), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        drain("t4_drain");
        check("t4_wr_count", wr_count - wr0, 32'd1000);
        end_download();

        // Memory stall with a second strobe -> overflow, first write retained
        wr0 = wr_count;
        start_download();
        send_header(8'd1, 8'd0, 8'h00, 8'h00, 2);
        stall  = 1'b1;
        a_byte = 8'($urandom);
        sb.push_back({22'd0, a_byte});
        send_byte(a_byte, 1);
        ioctl_wr = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_req_held", 32'(mem.mem_req), 32'd1);
        check("t5_addr_held", 32'(mem.mem_addr), 32'd0);
        check("t5_data_held", 32'(mem.mem_data), 32'(a_byte));
        send_byte(~a_byte, 1);
        ioctl_wr = 1'b0;
        check("t5_err_ovf", 32'(error), 32'd3);
        check("t5_data_kept", 32'(mem.mem_data), 32'(a_byte));
        repeat (14) @(negedge clk);
        check("t5_req_still", 32'(mem.mem_req), 32'd1);
        stall = 1'b0;
        drain("t5_drain");
        check("t5_wr_count", wr_count - wr0, 32'd1);
        check("t5_err_sticky", 32'(error), 32'd3);
        end_download();

        // Reset mid-PRG clears outputs in the same cycle
        start_download();
        send_header(8'd1, 8'd1, 8'hF9, 8'h20, 1);
        send_payload(22'd0, 100, 1);
        check("t6_mapper_pre", 32'(mapper), 32'h2F);
        a_byte = 8'($urandom);
        sb.push_back({22'd100, a_byte});
        ioctl_wr   = 1'b1;
        ioctl_data = a_byte;
        @(posedge clk);
        #1;
        check("t6_req_pre", 32'(mem.mem_req), 32'd1);
        reset    = 1'b1;
        ioctl_wr = 1'b0;
        #1;
        check("t6_req", 32'(mem.mem_req), 32'd0);
        check("t6_addr", 32'(mem.mem_addr), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_mapper", 32'(mapper), 32'd0);
        check("t6_mirroring", 32'(mirroring), 32'd0);
        check("t6_four", 32'(four_screen), 32'd0);
        check("t6_prg", 32'(prg_banks), 32'd0);
        check("t6_chr", 32'(chr_banks), 32'd0);
        check("t6_error", 32'(error), 32'd0);
        sb.delete();
        downloading = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_idle_after", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
